// File: rtl/tx_container.sv
// CAN 2.0A transmitter: sends one standard data frame with a 4-byte payload.
// Handles bit stuffing, CRC-15, arbitration loss with retry and bit-error abort.
module tx_container (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_clk,
    output logic        tx,
    input  logic        rx,
    input  logic [10:0] address,
    input  logic [31:0] data,
    input  logic        send_data
);

    typedef enum logic [3:0] {
        IDLE, SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  run_cnt_q, run_cnt_d;
    logic        last_bit_q, last_bit_d;
    logic [14:0] crc_q, crc_d;
    logic [10:0] id_q, id_d;
    logic [31:0] payload_q, payload_d;
    logic        tx_q, tx_d;
    logic        pending_q, pending_d;
    logic        lost_q, lost_d;
    logic [3:0]  rec_cnt_q, rec_cnt_d;
    logic        baud_s1_q, baud_s1_d, baud_s2_q, baud_s2_d, baud_prev_q, baud_prev_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic        send_prev_q, send_prev_d;

    logic        baud_rise, baud_fall, send_rise, stuff_region;
    state_t      adv_state;
    logic [4:0]  adv_cnt, field_last;
    logic [3:0]  id_idx, crc_idx;
    logic        adv_bit, crc_fb;

    always_comb begin
        baud_s1_d   = baud_clk;
        baud_s2_d   = baud_s1_q;
        baud_prev_d = baud_s2_q;
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        send_prev_d = send_data;
    end

    assign baud_rise    = baud_s2_q & ~baud_prev_q;
    assign baud_fall    = ~baud_s2_q & baud_prev_q;
    assign send_rise    = send_data & ~send_prev_q;
    assign stuff_region = state_q inside {SOF, ARB, CTRL, DATA, CRC};
    assign tx           = tx_q;

    // Position of the next unstuffed bit, given the field/index of the last one sent.
    always_comb begin
        case (state_q)
            ARB:     field_last = 5'd11;
            CTRL:    field_last = 5'd5;
            DATA:    field_last = 5'd31;
            CRC:     field_last = 5'd14;
            EOF:     field_last = 5'd6;
            IFS:     field_last = 5'd2;
            default: field_last = 5'd0;
        endcase
        adv_state = state_q;
        adv_cnt   = bit_cnt_q + 5'd1;
        if (bit_cnt_q == field_last) begin
            adv_cnt = 5'd0;
            case (state_q)
                SOF:     adv_state = ARB;
                ARB:     adv_state = CTRL;
                CTRL:    adv_state = DATA;
                DATA:    adv_state = CRC;
                CRC:     adv_state = CRC_DEL;
                CRC_DEL: adv_state = ACK;
                ACK:     adv_state = ACK_DEL;
                ACK_DEL: adv_state = EOF;
                EOF:     adv_state = IFS;
                default: adv_state = IDLE;
            endcase
        end
        id_idx  = 4'd10 - adv_cnt[3:0];
        crc_idx = 4'd14 - adv_cnt[3:0];
        case (adv_state)
            ARB:     adv_bit = (adv_cnt == 5'd11) ? 1'b0 : id_q[id_idx];
            CTRL:    adv_bit = (adv_cnt == 5'd3);
            DATA:    adv_bit = payload_q[5'd31 - adv_cnt];
            CRC:     adv_bit = crc_q[crc_idx];
            default: adv_bit = 1'b1;
        endcase
        crc_fb = adv_bit ^ crc_q[14];
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        run_cnt_d  = run_cnt_q;
        last_bit_d = last_bit_q;
        crc_d      = crc_q;
        id_d       = id_q;
        payload_d  = payload_q;
        tx_d       = tx_q;
        lost_d     = lost_q;
        rec_cnt_d  = rec_cnt_q;
        pending_d  = pending_q | send_rise;

        if (baud_rise && !lost_q) begin
            if (state_q == IDLE) begin
                tx_d = 1'b1;
                if (pending_q) begin
                    // SOF is dominant and the CRC starts at zero, so SOF leaves the CRC unchanged.
                    state_d    = SOF;
                    bit_cnt_d  = 5'd0;
                    id_d       = address;
                    payload_d  = data;
                    crc_d      = '0;
                    tx_d       = 1'b0;
                    last_bit_d = 1'b0;
                    run_cnt_d  = 3'd1;
                    pending_d  = send_rise;
                end
            end else if (stuff_region && run_cnt_q == 3'd5) begin
                tx_d       = ~last_bit_q;
                last_bit_d = ~last_bit_q;
                run_cnt_d  = 3'd1;
            end else begin
                state_d    = adv_state;
                bit_cnt_d  = adv_cnt;
                tx_d       = adv_bit;
                last_bit_d = adv_bit;
                run_cnt_d  = (adv_bit == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
                if (adv_state inside {ARB, CTRL, DATA})
                    crc_d = {crc_q[13:0], 1'b0} ^ (crc_fb ? 15'h4599 : 15'h0000);
            end
        end

        if (baud_fall) begin
            if (lost_q) begin
                if (rx_s2_q) begin
                    if (rec_cnt_q == 4'd10) begin
                        state_d   = IDLE;
                        lost_d    = 1'b0;
                        rec_cnt_d = 4'd0;
                    end else begin
                        rec_cnt_d = rec_cnt_q + 4'd1;
                    end
                end else begin
                    rec_cnt_d = 4'd0;
                end
            end else if (state_q == ARB) begin
                if (tx_q && !rx_s2_q) begin
                    lost_d    = 1'b1;
                    pending_d = 1'b1;
                    tx_d      = 1'b1;
                    rec_cnt_d = 4'd0;
                end
            end else if (!(state_q inside {IDLE, ACK, IFS}) && (rx_s2_q != tx_q)) begin
                // Count 31 wraps to 0 on the next bit start, giving three full IFS bits.
                state_d   = IFS;
                bit_cnt_d = 5'd31;
                tx_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            run_cnt_q   <= '0;
            last_bit_q  <= 1'b1;
            crc_q       <= '0;
            id_q        <= '0;
            payload_q   <= '0;
            tx_q        <= 1'b1;
            pending_q   <= 1'b0;
            lost_q      <= 1'b0;
            rec_cnt_q   <= '0;
            baud_s1_q   <= 1'b1;
            baud_s2_q   <= 1'b1;
            baud_prev_q <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            send_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            run_cnt_q   <= run_cnt_d;
            last_bit_q  <= last_bit_d;
            crc_q       <= crc_d;
            id_q        <= id_d;
            payload_q   <= payload_d;
            tx_q        <= tx_d;
            pending_q   <= pending_d;
            lost_q      <= lost_d;
            rec_cnt_q   <= rec_cnt_d;
            baud_s1_q   <= baud_s1_d;
            baud_s2_q   <= baud_s2_d;
            baud_prev_q <= baud_prev_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            send_prev_q <= send_prev_d;
        end
    end

endmodule

// File: tb/tb_tx_container.sv
`timescale 1ns/1ps
// Bench for tx_container: a table of frames checked against a bit-level CAN 2.0A
// reference, plus hand sequences for arbitration loss, bit error, held request and reset.
module tb_tx_container;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_clk = 1'b0;
    logic        send_data = 1'b0;
    logic        force_rx = 1'b0;
    logic [10:0] address = '0;
    logic [31:0] data = '0;
    logic        tx;
    logic        rx;

    int   checks = 0;
    int   errors = 0;
    logic exp_bits [0:199];
    logic cap_bits [0:199];
    int   exp_len = 0;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] payload;
        logic [15:0] prefix;
        int          prefix_len;
    } vec_t;
    vec_t vecs [4];

    assign rx = force_rx ? 1'b0 : tx;

    always #50 clk = ~clk;
    always #1000 baud_clk = ~baud_clk;

    tx_container dut (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx(tx), .rx(rx),
        .address(address), .data(data), .send_data(send_data)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference frame: unstuffed bits, CRC-15 over SOF..DATA, stuffing through CRC, fixed tail.
    task automatic build_frame(input logic [10:0] a, input logic [31:0] d);
        logic        raw [0:65];
        logic [14:0] crc;
        logic        fb, last;
        int          run;
        raw[0] = 1'b0;
        for (int i = 0; i < 11; i++) raw[1 + i] = a[10 - i];
        raw[12] = 1'b0; raw[13] = 1'b0; raw[14] = 1'b0;
        raw[15] = 1'b0; raw[16] = 1'b1; raw[17] = 1'b0; raw[18] = 1'b0;
        for (int i = 0; i < 32; i++) raw[19 + i] = d[31 - i];
        crc = '0;
        for (int i = 0; i < 51; i++) begin
            fb  = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int i = 0; i < 15; i++) raw[51 + i] = crc[14 - i];
        exp_len = 0;
        run = 0;
        last = 1'b1;
        for (int i = 0; i < 66; i++) begin
            exp_bits[exp_len] = raw[i];
            exp_len++;
            run  = (raw[i] == last) ? run + 1 : 1;
            last = raw[i];
            if (run == 5) begin
                exp_bits[exp_len] = ~last;
                exp_len++;
                last = ~last;
                run  = 1;
            end
        end
        for (int i = 0; i < 13; i++) begin
            exp_bits[exp_len] = 1'b1;
            exp_len++;
        end
    endtask

    task automatic applyStimulus(input logic [10:0] a, input logic [31:0] d, input int hold_ns);
        @(negedge clk);
        address   = a;
        data      = d;
        send_data = 1'b1;
        fork
            begin
                automatic int h = hold_ns;
                #(h) send_data = 1'b0;
            end
        join_none
    endtask

    task automatic wait_sof(output int found);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge baud_clk);
            if (tx === 1'b0) found = 1;
        end
    endtask

    task automatic capture_rest();
        cap_bits[0] = 1'b0;
        for (int i = 1; i < exp_len; i++) begin
            @(negedge baud_clk);
            cap_bits[i] = tx;
        end
    endtask

    task automatic check_frame(input string name);
        int mism;
        mism = -1;
        for (int i = 0; i < exp_len; i++)
            if (mism < 0 && cap_bits[i] !== exp_bits[i]) mism = i;
        checkOutput({name, " first bad bit index"}, mism, -1);
    endtask

    task automatic count_zeros(input int nbits, output int zeros);
        zeros = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge baud_clk);
            if (tx !== 1'b1) zeros++;
        end
    endtask

    initial begin
        int found, zeros, ones, idx, pfx;

        vecs[0] = '{11'h028, 32'hAAAAAAAA, 16'h00A8, 13};
        vecs[1] = '{11'h7FF, 32'h00000000, 16'h1F7D, 14};
        vecs[2] = '{11'h555, 32'h12345678, 16'h0555, 12};
        vecs[3] = '{11'h000, 32'hFFFFFFFF, 16'h0104, 14};

        #10 rst = 1'b0;
        #60 checkOutput("tx during reset", tx, 1);
        #40 rst = 1'b1;
        count_zeros(20, zeros);
        checkOutput("idle without request", zeros, 0);

        for (int v = 0; v < 4; v++) begin
            build_frame(vecs[v].addr, vecs[v].payload);
            applyStimulus(vecs[v].addr, vecs[v].payload, 3000);
            wait_sof(found);
            checkOutput($sformatf("vec%0d sof seen", v), found, 1);
            if (found == 1) begin
                capture_rest();
                pfx = 0;
                for (int i = 0; i < vecs[v].prefix_len; i++) pfx = (pfx << 1) | int'(cap_bits[i]);
                checkOutput($sformatf("vec%0d sof+id prefix", v), pfx, int'(vecs[v].prefix));
                check_frame($sformatf("vec%0d frame", v));
            end
            count_zeros(15, zeros);
            checkOutput($sformatf("vec%0d single frame", v), zeros, 0);
        end

        $display("[TB] arbitration loss on first recessive ID bit");
        build_frame(11'h028, 32'hAAAAAAAA);
        applyStimulus(11'h028, 32'hAAAAAAAA, 3000);
        wait_sof(found);
        checkOutput("arb sof seen", found, 1);
        for (int i = 1; i <= 7; i++) @(negedge baud_clk);
        checkOutput("arb bit7 recessive", tx, 1);
        force_rx = 1'b1;
        #500 force_rx = 1'b0;
        ones = 0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge baud_clk);
            if (tx === 1'b0) found = 1;
            else ones++;
        end
        checkOutput("arb recessive bits before retry", ones, 11);
        if (found == 1) begin
            capture_rest();
            check_frame("arb retry frame");
        end
        count_zeros(15, zeros);
        checkOutput("arb single retry", zeros, 0);

        $display("[TB] bit error in data field");
        applyStimulus(11'h028, 32'hAAAAAAAA, 3000);
        wait_sof(found);
        checkOutput("err sof seen", found, 1);
        idx = 30;
        while (idx < exp_len - 1 && exp_bits[idx] != 1'b1) idx++;
        for (int i = 1; i <= idx; i++) @(negedge baud_clk);
        checkOutput("err data bit recessive", tx, 1);
        force_rx = 1'b1;
        #500 force_rx = 1'b0;
        count_zeros(40, zeros);
        checkOutput("err abort without retry", zeros, 0);

        $display("[TB] reset during data field");
        applyStimulus(11'h028, 32'hAAAAAAAA, 3000);
        wait_sof(found);
        checkOutput("rst sof seen", found, 1);
        idx = 30;
        while (idx < exp_len - 1 && exp_bits[idx] != 1'b0) idx++;
        for (int i = 1; i <= idx; i++) @(negedge baud_clk);
        checkOutput("rst data bit dominant", tx, 0);
        #100 rst = 1'b0;
        #1 checkOutput("rst forces tx high", tx, 1);
        #99 rst = 1'b1;
        count_zeros(20, zeros);
        checkOutput("rst quiet after release", zeros, 0);
        applyStimulus(11'h028, 32'hAAAAAAAA, 3000);
        wait_sof(found);
        checkOutput("rst recover sof seen", found, 1);
        if (found == 1) begin
            capture_rest();
            check_frame("rst recover frame");
        end

        $display("[TB] request held high for 300 us");
        build_frame(11'h555, 32'h12345678);
        applyStimulus(11'h555, 32'h12345678, 300000);
        wait_sof(found);
        checkOutput("hold sof seen", found, 1);
        address = 11'h7FF;
        data    = 32'h0;
        if (found == 1) begin
            capture_rest();
            check_frame("hold frame");
        end
        count_zeros(100, zeros);
        checkOutput("hold only one frame", zeros, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_container.md
TX_CONTAINER -- requirements
Module: tx_container

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 baud_clk  input  1  bit-timing strobe, sampled as data in the clk domain, not used as a clock.
REQ-006 tx  output  1  CAN bus drive: 0 = dominant, 1 = recessive.
REQ-007 rx  input  1  CAN bus readback, used for arbitration and bit monitoring.
REQ-008 address  input  11  standard identifier, latched at frame start.
REQ-009 data  input  32  payload, latched at frame start, sent MSB first.
REQ-010 send_data  input  1  transmit request.

Function
REQ-011 baud_clk and rx SHALL each pass through a 2-flop synchronizer.
REQ-012 A synchronized baud_clk rising edge SHALL start each bit period; tx SHALL update one clk later.
REQ-013 A synchronized baud_clk falling edge SHALL sample rx at mid-bit.
REQ-014 A send_data 0->1 transition SHALL set a pending flag; holding the input high SHALL NOT request another frame.
REQ-015 When pending is set and the FSM is in IDLE, the block SHALL latch address and data and start SOF at the next bit start, then clear pending.
REQ-016 The frame SHALL be CAN 2.0A with these fields in order:
- SOF: 0
- ID[10:0]: MSB first
- RTR: 0
- IDE: 0
- r0: 0
- DLC: 4'b0100
- DATA[31:0]
- CRC[14:0]
- CRC delimiter: 1
- ACK slot: 1
- ACK delimiter: 1
- EOF: 7 × 1
- IFS: 3 × 1
REQ-017 FSM states SHALL be IDLE, SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS, each advancing by bit count; IFS SHALL return to IDLE.
REQ-018 The CRC SHALL be CRC-15, polynomial 0x4599, initial value 0, computed over unstuffed bits from SOF through the last DATA bit.
REQ-019 Bit stuffing SHALL apply from SOF through the CRC:
- after 5 consecutive equal bits, insert one complement bit;
- the stuff bit counts toward the next run;
- stuff bits SHALL NOT enter the CRC.
REQ-020 Stuffing SHALL NOT apply from CRC_DEL onward.
REQ-021 In IDLE and IFS, tx SHALL be 1.
REQ-022 Arbitration loss: during ARB, if tx=1 but rx=0 is sampled, the block SHALL:
- drive tx=1 for the rest of the frame;
- re-set pending;
- return to IDLE after 11 consecutive recessive samples;
- then retry.
REQ-023 Bit error: outside ARB and the ACK slot, a sampled rx differing from tx SHALL abort the frame, drive tx=1, enter IFS, and drop the frame with no retry.
REQ-024 The ACK slot value SHALL be sampled but ignored: no retransmission and no error on a missing ACK.
REQ-025 A new send_data edge during a frame SHALL set pending only; the current frame SHALL NOT change.

Reset
REQ-026 While rst=0, the block SHALL be in IDLE with:
- tx=1
- pending, counters and CRC cleared
- synchronizers set to 1
REQ-027 Asserting rst mid-frame SHALL force tx=1 immediately (asynchronously) and discard the frame.
REQ-028 After release, tx SHALL stay 1 until a new send_data rising edge.

Verification
REQ-029 Reset: rst=0 for 100 ns, then 1; send_data held 0 -> tx=1 indefinitely.
REQ-030 Loopback rx=tx, address=11'h028, data=32'hAAAAAAAA, send_data pulsed for 3 µs, baud_clk period 2 µs -> tx must match the bit sequence computed by an independent CAN 2.0A model:
- SOF 0;
- ID bits 0,0,0,0, then stuff bit 1, then 0,1,0,1,0,0,0;
- stuffing, CRC, 7-bit EOF and 3-bit IFS as specified;
- then idle at 1.
REQ-031 Loopback frame -> exactly one frame, no abort (ACK absent is ignored).
REQ-032 With send_data held high for 300 µs -> only one frame is sent.
REQ-033 Force rx=0 on the first recessive ID bit -> tx=1 until 11 recessive bits are seen, then a full retransmission.
REQ-034 Assert rst during the DATA field -> tx=1 within one clk; no further bits until a new request.
